// File: rtl/uart_tx_fifo_param_if.sv
// Handshake bundle for uart_tx_fifo_param: load strobe and data in, serial line and FIFO status out.
// ParityOdd exists only when UART_TX_PARITY_EN is defined.
interface uart_tx_fifo_param_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned FIFO_AW   = 4
);
   logic                 TxFifoLoad;
   logic [DATA_BITS-1:0] TxData;
`ifdef UART_TX_PARITY_EN
   logic                 ParityOdd;
`endif
   logic                 Tx;
   logic                 TxFifoEmpty;
   logic                 TxFifoFull;
   logic [FIFO_AW:0]     TxFifoCount;
   logic                 TxBusy;

   modport master (
`ifdef UART_TX_PARITY_EN
      output ParityOdd,
`endif
      output TxFifoLoad,
      output TxData,
      input  Tx,
      input  TxFifoEmpty,
      input  TxFifoFull,
      input  TxFifoCount,
      input  TxBusy
   );

   modport slave (
`ifdef UART_TX_PARITY_EN
      input  ParityOdd,
`endif
      input  TxFifoLoad,
      input  TxData,
      output Tx,
      output TxFifoEmpty,
      output TxFifoFull,
      output TxFifoCount,
      output TxBusy
   );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a 2^FIFO_AW-entry transmit FIFO; frames are sent back-to-back.
// Define UART_TX_PARITY_EN to add the parity bit and the ParityOdd input.
module uart_tx_fifo_param #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_AW      = 4
) (
   input logic                  clock,
   input logic                  nReset,
   uart_tx_fifo_param_if.slave  bus
);
   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam logic [BaudW-1:0]  BaudLast  = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]   DataLast  = BitW'(DATA_BITS - 1);
   localparam logic [BitW-1:0]   StopLast  = BitW'(STOP_BITS - 1);
   localparam logic [FIFO_AW:0]  CountFull = (FIFO_AW + 1)'(Depth);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } txState_e;

   logic [DATA_BITS-1:0] fifoMem [Depth];
   logic [FIFO_AW-1:0]   wrPtrQ, rdPtrQ;
   logic [FIFO_AW:0]     countQ;
   logic                 push, pop, fifoEmpty, fifoFull;
   logic [DATA_BITS-1:0] head;

   txState_e             stateQ, stateD;
   logic [BaudW-1:0]     baudQ, baudD;
   logic [BitW-1:0]      bitQ, bitD;
   logic [DATA_BITS-1:0] shiftQ, shiftD;
   logic                 txQ, txD;
   logic                 bitEnd;
`ifdef UART_TX_PARITY_EN
   logic                 parityQ, parityD;
`endif

   // Flags come from the occupancy count so pointer equality never has to disambiguate.
   assign fifoEmpty = (countQ == '0);
   assign fifoFull  = (countQ == CountFull);
   assign push      = bus.TxFifoLoad && !fifoFull;
   assign head      = fifoMem[rdPtrQ];

   always_ff @(posedge clock) begin
      if (push) fifoMem[wrPtrQ] <= bus.TxData;
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         if (push) wrPtrQ <= wrPtrQ + 1'b1;
         if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
         if (push && !pop)      countQ <= countQ + 1'b1;
         else if (pop && !push) countQ <= countQ - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         stateQ  <= StIdle;
         baudQ   <= '0;
         bitQ    <= '0;
         shiftQ  <= '0;
         txQ     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parityQ <= 1'b0;
`endif
      end else begin
         stateQ  <= stateD;
         baudQ   <= baudD;
         bitQ    <= bitD;
         shiftQ  <= shiftD;
         txQ     <= txD;
`ifdef UART_TX_PARITY_EN
         parityQ <= parityD;
`endif
      end
   end

   always_comb begin
      stateD  = stateQ;
      baudD   = baudQ;
      bitD    = bitQ;
      shiftD  = shiftQ;
      txD     = txQ;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parityD = parityQ;
`endif
      bitEnd  = (baudQ == BaudLast);
      if (stateQ != StIdle) baudD = bitEnd ? '0 : baudQ + 1'b1;

      case (stateQ)
         StIdle: begin
            txD   = 1'b1;
            baudD = '0;
            bitD  = '0;
            if (!fifoEmpty) begin
               pop    = 1'b1;
               shiftD = head;
               txD    = 1'b0;
               stateD = StStart;
`ifdef UART_TX_PARITY_EN
               parityD = (^head) ^ bus.ParityOdd;
`endif
            end
         end
         StStart: begin
            if (bitEnd) begin
               txD    = shiftQ[0];
               bitD   = '0;
               stateD = StData;
            end
         end
         StData: begin
            if (bitEnd) begin
               if (bitQ == DataLast) begin
                  bitD = '0;
`ifdef UART_TX_PARITY_EN
                  txD    = parityQ;
                  stateD = StParity;
`else
                  txD    = 1'b1;
                  stateD = StStop;
`endif
               end else begin
                  bitD   = bitQ + 1'b1;
                  shiftD = shiftQ >> 1;
                  txD    = shiftQ[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bitEnd) begin
               txD    = 1'b1;
               bitD   = '0;
               stateD = StStop;
            end
         end
`endif
         StStop: begin
            if (bitEnd) begin
               if (bitQ == StopLast) begin
                  bitD = '0;
                  // Chain straight into the next start bit so frames leave no idle gap.
                  if (!fifoEmpty) begin
                     pop    = 1'b1;
                     shiftD = head;
                     txD    = 1'b0;
                     stateD = StStart;
`ifdef UART_TX_PARITY_EN
                     parityD = (^head) ^ bus.ParityOdd;
`endif
                  end else begin
                     txD    = 1'b1;
                     stateD = StIdle;
                  end
               end else begin
                  bitD = bitQ + 1'b1;
               end
            end
         end
         default: stateD = StIdle;
      endcase
   end

   assign bus.Tx          = txQ;
   assign bus.TxFifoEmpty = fifoEmpty;
   assign bus.TxFifoFull  = fifoFull;
   assign bus.TxFifoCount = countQ;
   assign bus.TxBusy      = (stateQ != StIdle);
endmodule
